seq_mag_compare: RTL and testbench
==================================

# seq_mag_compare

Parametrised, multi-cycle magnitude comparator. It takes two WIDTH-bit operands in one handshake and scans them MSB-first, DIGIT bits per clock. It stops early at the first differing digit and returns a one-hot {A>B, A==B, A<B} result with a done pulse. It succeeds the fixed 4-bit combinational comparator stage and adds:
- a signed/unsigned mode
- a start/busy/done handshake
- a latency/area trade-off through DIGIT

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per cycle; must be ≥ 1 and divide WIDTH. NDIG = WIDTH/DIGIT.
- EARLY_EXIT, 1: 1 ends the scan at the first differing digit; 0 always scans all NDIG digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a compare; accepted only in IDLE.
- signed_mode  in  1  0 compares as unsigned, 1 as two's complement; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; Y is valid from this cycle on.
- Y  out  3  {gt, eq, lt}, one-hot; held until the next done or rst.

## Operation
- States: IDLE → SCAN → DONE → IDLE.
- IDLE, on start=1:
  - Load shift registers SA=A and SB=B.
  - If signed_mode=1, invert bit WIDTH-1 of both SA and SB. This offset-binary trick makes the unsigned scan give the signed order.
  - Load digit counter cnt=NDIG-1, then go to SCAN.
  - Inputs are not sampled again until the next accepted start.
- SCAN, each cycle compares the top DIGIT bits of SA and SB:
  - Differ and EARLY_EXIT=1: register the result (gt or lt) into Y and go to DONE.
  - Differ and EARLY_EXIT=0: record the result in sticky flag `decided`; later digits do not overwrite it.
  - Equal and cnt≠0: shift SA and SB left by DIGIT, decrement cnt, stay in SCAN.
  - cnt=0: go to DONE. Y takes the first recorded result, otherwise eq (3'b010).
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start is ignored in SCAN and DONE; no queueing. The earliest next accept is the cycle after done.
- Y never holds an encoding other than 000, 100, 010 or 001.
- rst in any state, including mid-SCAN:
  - next state IDLE, busy=0, done=0, Y=3'b000, cnt=0, decided=0.
  - The aborted compare produces no done pulse.
- rst and start in the same cycle: rst wins; start is dropped.
- Reset values: busy=0, done=0, Y=3'b000 ("no result yet").

## Timing
- Let start be sampled at edge 0 and k be the 1-based index of the deciding digit, with k=NDIG when the operands are equal.
- SCAN occupies cycles 1..k (with EARLY_EXIT=0, cycles 1..NDIG).
- done is high in cycle k+1. Y changes on that same edge.
- Latency:
  - minimum 2 cycles (MSB digit differs, EARLY_EXIT=1);
  - maximum NDIG+1 cycles.
- Throughput: one compare per k+2 cycles at best, because IDLE lasts one cycle.
- busy rises on edge 0+ and falls after the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package cmp_pkg contains:
  - state enum {S_IDLE, S_SCAN, S_DONE};
  - constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000.
- Sub-module cmp_digit: purely combinational DIGIT-bit compare, output {gt, eq, lt}, instantiated once on the top digits of SA and SB.
- Top level holds the FSM, shift registers, cnt ($clog2(NDIG) bits, minimum 1), the decided flag and the output registers.
- Elaboration-time check: WIDTH % DIGIT == 0, otherwise $error.

## Test plan
Unless noted, WIDTH=8, DIGIT=2, EARLY_EXIT=1, with start pulsed for one cycle at edge 0.
- A=8'h80, B=8'h7F, signed_mode=0 → Y=100; done in cycle 2; busy high in cycles 1–2 only.
- A=8'h80, B=8'h7F, signed_mode=1 (−128 vs 127) → Y=001; done in cycle 2.
- A=B=8'hA5 in both modes → Y=010; done in cycle 5. Also A=8'hFF, B=8'h00, signed_mode=1 (−1 vs 0) → Y=001.
- A=8'h01, B=8'h00 → Y=100, done in cycle 5. Repeat with EARLY_EXIT=0 and A=8'hC0, B=8'h40 → Y=100, done in cycle 5, not cycle 2.
- start re-pulsed in cycles 1–4 of a compare → ignored: exactly one done pulse, Y from the first operands. Then rst in cycle 2 of a new compare → busy=0, Y=000 the next cycle, no done pulse.
- WIDTH=16, DIGIT=4 plus WIDTH=5, DIGIT=1: random signed and unsigned operands checked against a $signed/$unsigned reference model. Check Y is always one-hot and latency ≤ NDIG+1.

Source files
------------

// File: rtl/seq_mag_compare_pkg.sv
// Shared types and result encodings for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One-hot result encodings {gt, eq, lt}; CMP_NONE means "no result yet".
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/seq_mag_compare_if.sv
// Request/response bundle of the sequential magnitude comparator.
//
// Handshake: the master raises start together with signed_mode, A and B; the
// request is accepted on the rising edge where start=1 and busy=0. From that
// edge busy stays high until the end of the done cycle. done is a one-cycle
// pulse and Y is valid from that cycle until the next done or reset. A start
// seen while busy=1 is dropped, never queued.
interface seq_mag_compare_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [2:0]       Y;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, Y
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, Y
    );
endinterface

// File: rtl/seq_mag_compare_cmp_digit.sv
// Combinational compare of one DIGIT-bit slice, one-hot {gt, eq, lt}.
module cmp_digit
    import cmp_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic [2:0]       res
);

    // Unsigned compare of the slice; sign handling is done upstream.
    always_comb begin
        res = CMP_EQ;
        if (a > b) begin
            res = CMP_GT;
        end else if (a < b) begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/seq_mag_compare.sv
// Multi-cycle magnitude comparator: scans two operands MSB-first, DIGIT bits
// per clock, optionally stopping at the first differing digit.
module seq_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    seq_mag_compare_if.slave    bus,
    output logic [1:0]          state_dbg
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Flipping the sign bit of both operands maps two's complement onto
    // offset binary, so the unsigned scan yields the signed ordering.
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
        $error("seq_mag_compare: DIGIT must divide WIDTH, WIDTH >= 2, DIGIT >= 1");
    end

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic [2:0]       dec_res;
    logic [2:0]       y_q;
    logic [2:0]       dig_res;

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a   (sa[WIDTH-1 -: DIGIT]),
        .b   (sb[WIDTH-1 -: DIGIT]),
        .res (dig_res)
    );

    // Outputs decode registered state only; no input reaches them combinationally.
    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = (state == S_DONE);
    assign bus.Y     = y_q;
    assign state_dbg = state;

    // FSM, operand shift registers, digit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dec_res <= CMP_NONE;
            y_q     <= CMP_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sa      <= bus.A ^ (bus.signed_mode ? MSB_MASK : '0);
                        sb      <= bus.B ^ (bus.signed_mode ? MSB_MASK : '0);
                        cnt     <= CW'(NDIG - 1);
                        decided <= 1'b0;
                        dec_res <= CMP_NONE;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if ((EARLY_EXIT != 0) && (dig_res != CMP_EQ)) begin
                        y_q   <= dig_res;
                        state <= S_DONE;
                    end else begin
                        // Only the first differing digit decides the result.
                        if ((dig_res != CMP_EQ) && !decided) begin
                            decided <= 1'b1;
                            dec_res <= dig_res;
                        end
                        if (cnt == '0) begin
                            if (decided) begin
                                y_q <= dec_res;
                            end else begin
                                y_q <= dig_res;
                            end
                            state <= S_DONE;
                        end else begin
                            sa  <= sa << DIGIT;
                            sb  <= sb << DIGIT;
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Bench for seq_mag_compare: four configurations share one clock and reset and
// are exercised one at a time against a signed/unsigned reference model.
module tb_seq_mag_compare;
    import cmp_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // sel 0: 8/2 early exit, sel 1: 8/2 full scan, sel 2: 16/4, sel 3: 5/1
    int cfg_w  [4] = '{8, 8, 16, 5};
    int cfg_d  [4] = '{2, 2, 4, 1};
    int cfg_ee [4] = '{1, 0, 1, 1};

    seq_mag_compare_if #(.WIDTH(8))  if8  ();
    seq_mag_compare_if #(.WIDTH(8))  if8n ();
    seq_mag_compare_if #(.WIDTH(16)) if16 ();
    seq_mag_compare_if #(.WIDTH(5))  if5  ();

    logic [1:0] st8, st8n, st16, st5;

    seq_mag_compare #(.WIDTH(8),  .DIGIT(2), .EARLY_EXIT(1)) u8  (.clk(clk), .rst(rst), .bus(if8),  .state_dbg(st8));
    seq_mag_compare #(.WIDTH(8),  .DIGIT(2), .EARLY_EXIT(0)) u8n (.clk(clk), .rst(rst), .bus(if8n), .state_dbg(st8n));
    seq_mag_compare #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u16 (.clk(clk), .rst(rst), .bus(if16), .state_dbg(st16));
    seq_mag_compare #(.WIDTH(5),  .DIGIT(1), .EARLY_EXIT(1)) u5  (.clk(clk), .rst(rst), .bus(if5),  .state_dbg(st5));

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] y_obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if8.done;
            1: return if8n.done;
            2: return if16.done;
            default: return if5.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if8.busy;
            1: return if8n.busy;
            2: return if16.busy;
            default: return if5.busy;
        endcase
    endfunction

    function automatic logic [2:0] get_y(input int sel);
        case (sel)
            0: return if8.Y;
            1: return if8n.Y;
            2: return if16.Y;
            default: return if5.Y;
        endcase
    endfunction

    // Reference: operands as plain integers, sign-extended when signed.
    function automatic logic [2:0] ref_y(input logic [15:0] a, input logic [15:0] b,
                                         input int w, input logic sm);
        longint va, vb, m;
        m  = (longint'(1) << w);
        va = longint'(a) & (m - 1);
        vb = longint'(b) & (m - 1);
        if (sm && a[w-1]) va = va - m;
        if (sm && b[w-1]) vb = vb - m;
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b001;
        return 3'b010;
    endfunction

    // Cycle (counted from the accept edge) in which done must be seen.
    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b,
                                   input int w, input int d, input int ee);
        if (ee == 0) return w / d + 1;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return (w - 1 - i) / d + 2;
        end
        return w / d + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic st, input logic sm,
                         input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0: begin if8.start = st;  if8.signed_mode = sm;  if8.A = a[7:0];  if8.B = b[7:0];  end
            1: begin if8n.start = st; if8n.signed_mode = sm; if8n.A = a[7:0]; if8n.B = b[7:0]; end
            2: begin if16.start = st; if16.signed_mode = sm; if16.A = a;      if16.B = b;      end
            default: begin if5.start = st; if5.signed_mode = sm; if5.A = a[4:0]; if5.B = b[4:0]; end
        endcase
    endtask

    task automatic do_cmp(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic repulse);
        int lat;
        int exp_lat;
        lat     = 0;
        exp_lat = ref_lat(a, b, cfg_w[sel], cfg_d[sel], cfg_ee[sel]);
        exp_q.push_back(ref_y(a, b, cfg_w[sel], sm));
        @(negedge clk);
        drive(sel, 1'b1, sm, a, b);
        @(posedge clk);
        for (int c = 1; c <= 64 && lat == 0; c++) begin
            @(negedge clk);
            if (repulse) drive(sel, 1'b1, ~sm, ~a, b ^ 16'h5a5a);
            else         drive(sel, 1'b0, sm, a, b);
            check("busy_during", get_busy(sel), 1'b1);
            if (get_done(sel) === 1'b1) lat = c;
        end
        drive(sel, 1'b0, sm, a, b);
        check("latency", lat, exp_lat);
        @(negedge clk);
        check("busy_after", get_busy(sel), 1'b0);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (get_done(s) === 1'b1) begin
                y_obs = get_y(s);
                check("y_onehot", (y_obs == 3'b100 || y_obs == 3'b010 || y_obs == 3'b001), 1);
                if (exp_q.size() == 0) check("spurious_done", 1, 0);
                else                   check("y", y_obs, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check("rst_busy", get_busy(s), 1'b0);
            check("rst_done", get_done(s), 1'b0);
            check("rst_y", get_y(s), 3'b000);
        end
        rst = 1'b0;

        // directed cases, 8-bit / 2-bit digits, early exit
        do_cmp(0, 16'h80, 16'h7F, 1'b0, 1'b0);
        do_cmp(0, 16'h80, 16'h7F, 1'b1, 1'b0);
        do_cmp(0, 16'hA5, 16'hA5, 1'b0, 1'b0);
        do_cmp(0, 16'hA5, 16'hA5, 1'b1, 1'b0);
        do_cmp(0, 16'hFF, 16'h00, 1'b1, 1'b0);
        do_cmp(0, 16'h01, 16'h00, 1'b0, 1'b0);
        do_cmp(0, 16'h3C, 16'h3D, 1'b0, 1'b1);

        // full-scan configuration
        do_cmp(1, 16'hC0, 16'h40, 1'b0, 1'b0);
        do_cmp(1, 16'hA5, 16'hA5, 1'b1, 1'b0);
        do_cmp(1, 16'h40, 16'h80, 1'b1, 1'b0);

        // reset in cycle 2 of a compare: no done, outputs cleared
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h01, 16'h00);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h01, 16'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", if8.busy, 1'b0);
        check("abort_done", if8.done, 1'b0);
        check("abort_y", if8.Y, 3'b000);
        check("abort_state", st8, S_IDLE);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_quiet", if8.busy, 1'b0);

        // reset and start together: start dropped
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h80, 16'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h80, 16'h00);
        check("rst_start_busy", if8.busy, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_start_quiet", if8.busy, 1'b0);

        // random operands, both modes
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 5 == 0) ? ra : 16'($urandom_range(0, 65535));
            do_cmp(2, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom_range(0, 31));
            rb = (i % 6 == 0) ? ra : 16'($urandom_range(0, 31));
            do_cmp(3, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            do_cmp(1, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
